pb_event_decoder: RTL and testbench
===================================

Name: pb_event_decoder

Overview:
- Consumes the clean, debounced push-button level produced by the debounce stage and turns it into discrete one-cycle events for downstream control logic (counters, stopwatches, mode FSMs).
- Events produced: press, release, short click, long press and auto-repeat.
- Sits directly after the debounce stage; runs entirely in the clk_100 domain.

Parameters:
- LONG_CYCLES, 100, consecutive high samples of pb_de needed to declare a long press (legal range >= 2).
- REPEAT_CYCLES, 20, period in clk_100 cycles of repeat_pulse while held after a long press (legal range >= 1).
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk_100  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pb_de  in  1  debounced button level, synchronous to clk_100, 1 = pressed.
- press_pulse  out  1  one cycle high on press.
- release_pulse  out  1  one cycle high on release.
- short_click  out  1  one cycle high on a release that occurs before a long press.
- long_pulse  out  1  one cycle high when the hold reaches LONG_CYCLES.
- repeat_pulse  out  1  one cycle high every REPEAT_CYCLES while held after long_pulse.
- held  out  1  level; 1 while the FSM is not IDLE.

Behaviour:
- Reset: rst (asynchronous, active-high; clock clk_100) forces state IDLE, cnt=0 and all outputs 0 immediately.
  - No release_pulse or short_click is generated by a reset that arrives mid-press.
  - After reset, a button that is already high is treated as a new press on the first sampled edge.
- All outputs are registered. Each pulse output is high for exactly one cycle and is cleared on the next edge unless re-set.
- FSM states: IDLE, PRESSED, LONG_HELD. Each transition below occurs at one clk_100 rising edge.
- IDLE:
  - pb_de=1: go to PRESSED, cnt<=1, press_pulse<=1, held<=1.
  - pb_de=0: stay in IDLE.
- PRESSED:
  - pb_de=0: go to IDLE, release_pulse<=1, short_click<=1, held<=0, cnt<=0.
  - pb_de=1 and cnt==LONG_CYCLES-1: go to LONG_HELD, long_pulse<=1, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- LONG_HELD:
  - pb_de=0: go to IDLE, release_pulse<=1, short_click stays 0, held<=0, cnt<=0.
  - pb_de=1 and cnt==REPEAT_CYCLES-1: repeat_pulse<=1, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- Timing from the edge E0 that first samples pb_de=1:
  - press_pulse is high after E0.
  - long_pulse is high after edge E0+LONG_CYCLES-1.
  - The first repeat_pulse is high REPEAT_CYCLES cycles after long_pulse, and then every REPEAT_CYCLES cycles.
- REPEAT_CYCLES=1: repeat_pulse is high every cycle in LONG_HELD.
- Release has priority over the long/repeat compare in the same cycle. If pb_de=0 at the edge where cnt would hit the threshold, only the release events fire.
- A 1-cycle low glitch is not filtered: it ends the press, and re-assertion starts a new press. Filtering is the debounce stage's job.
- Back-to-back press/release is legal:
  - pb_de pattern 1,0,1 on consecutive edges gives press, release+short_click, press on consecutive cycles.
- The counter never wraps: it is always reset at its threshold or on release.

Decomposition:
- Package pb_event_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_PRESSED=2'd1, ST_LONG=2'd2;
  - default LONG_CYCLES and REPEAT_CYCLES values shared with other button consumers.
- Single module. The FSM and counter are tightly coupled, so no sub-module.
- Encoding 2'd3 is unreachable; the implementation recovers from it to IDLE on the next edge.

Test Plan (LONG_CYCLES=5, REPEAT_CYCLES=3 unless noted):
- Short press:
  - Stimulus: pb_de high for 3 edges, then low.
  - Required: press_pulse after E0; release_pulse and short_click together after E3; long_pulse never; held high exactly 3 cycles.
- Long press with repeat:
  - Stimulus: pb_de high for 12 edges.
  - Required: press after E0, long_pulse after E4, repeat_pulse after E7 and E10, release after E12; short_click stays 0.
- Threshold race:
  - Stimulus: pb_de high for exactly 4 edges, low at E4.
  - Required: release and short_click after E4; long_pulse stays 0.
- Glitch/back-to-back:
  - Stimulus: pb_de = 1,0,1,0 on E0..E3.
  - Required: press E0, release+click E1, press E2, release+click E3.
- Reset mid-hold:
  - Stimulus: assert rst asynchronously in LONG_HELD.
  - Required: all outputs 0 immediately, no release_pulse; with pb_de still high after rst drops, a new press_pulse on the first edge.
- REPEAT_CYCLES=1:
  - Stimulus: hold pb_de for 8 edges.
  - Required: long_pulse after E4; repeat_pulse high on each of the following cycles until release.

Source files
------------

// File: rtl/pb_event_pkg.sv
// Shared definitions for push-button event consumers: FSM state encoding
// and default hold timings.
package pb_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } pb_state_t;

    localparam int PB_LONG_CYCLES_DEF   = 100;
    localparam int PB_REPEAT_CYCLES_DEF = 20;
    localparam int PB_CNT_W_DEF         = 8;

endpackage

// File: rtl/pb_event_decoder_if.sv
// Button level in, one-cycle events out; the decoder side is the slave.
interface pb_event_decoder_if;

    // No handshake: pb_de is sampled every clk_100 edge and each pulse is a
    // fire-and-forget strobe that the consumer must take in the cycle it is high.
    logic pb_de;
    logic press_pulse;
    logic release_pulse;
    logic short_click;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output pb_de,
        input  press_pulse, release_pulse, short_click,
        input  long_pulse, repeat_pulse, held
    );

    modport slave (
        input  pb_de,
        output press_pulse, release_pulse, short_click,
        output long_pulse, repeat_pulse, held
    );

endinterface

// File: rtl/pb_event_decoder.sv
// Turns a debounced button level into press/release/click/long/repeat strobes.
// One shared hold counter serves both the long-press and the repeat timing.
module pb_event_decoder
    import pb_event_pkg::*;
#(
    parameter int LONG_CYCLES   = PB_LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = PB_REPEAT_CYCLES_DEF,
    parameter int CNT_W         = PB_CNT_W_DEF
) (
    input  logic                clk_100,
    input  logic                rst,
    pb_event_decoder_if.slave   pb,
    output pb_state_t           state_dbg
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    pb_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d, short_d, long_d, repeat_d, held_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pb.pb_de) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_W'(1);
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                // Release is tested first so it wins over a same-edge threshold hit.
                if (!pb.pb_de) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LONG: begin
                if (!pb.pb_de) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            pb.press_pulse   <= 1'b0;
            pb.release_pulse <= 1'b0;
            pb.short_click   <= 1'b0;
            pb.long_pulse    <= 1'b0;
            pb.repeat_pulse  <= 1'b0;
            pb.held          <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pb.press_pulse   <= press_d;
            pb.release_pulse <= release_d;
            pb.short_click   <= short_d;
            pb.long_pulse    <= long_d;
            pb.repeat_pulse  <= repeat_d;
            pb.held          <= held_d;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_pb_event_decoder.sv
// Drives two decoders (REPEAT_CYCLES 3 and 1) with identical button traffic and
// scores each against a hold-length model of the event timing.
module tb_pb_event_decoder;
    import pb_event_pkg::*;

    localparam int LONG_C = 5;
    localparam int W      = 6;

    logic clk_100 = 1'b0;
    logic rst     = 1'b1;

    pb_event_decoder_if if_a ();
    pb_event_decoder_if if_b ();
    pb_state_t state_a, state_b;

    pb_event_decoder #(.LONG_CYCLES(LONG_C), .REPEAT_CYCLES(3), .CNT_W(8)) dut_a (
        .clk_100   (clk_100),
        .rst       (rst),
        .pb        (if_a.slave),
        .state_dbg (state_a)
    );

    pb_event_decoder #(.LONG_CYCLES(LONG_C), .REPEAT_CYCLES(1), .CNT_W(8)) dut_b (
        .clk_100   (clk_100),
        .rst       (rst),
        .pb        (if_b.slave),
        .state_dbg (state_b)
    );

    // ---------------- clock ----------------
    always #5 clk_100 = ~clk_100;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Model state: whether the button is in a hold and how many high samples so far.
    bit held_m[2];
    int len_m[2];
    int rep_m[2] = '{3, 1};

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (press,rel,short,long,rep,held) at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Expected outputs after the next edge, derived from hold length:
    // long at sample LONG_C, repeats every rep samples after that.
    function automatic logic [W-1:0] model_step(input int d, input bit v);
        logic p, r, s, l, rp;
        p = 0; r = 0; s = 0; l = 0; rp = 0;
        if (v) begin
            if (!held_m[d]) begin
                p = 1;
                len_m[d] = 1;
            end else begin
                len_m[d]++;
            end
            if (len_m[d] == LONG_C) l = 1;
            if (len_m[d] > LONG_C && ((len_m[d] - LONG_C) % rep_m[d]) == 0) rp = 1;
        end else if (held_m[d]) begin
            r = 1;
            s = (len_m[d] < LONG_C);
            len_m[d] = 0;
        end
        held_m[d] = v;
        return {p, r, s, l, rp, v};
    endfunction

    function automatic logic [W-1:0] got_a();
        return {if_a.press_pulse, if_a.release_pulse, if_a.short_click,
                if_a.long_pulse, if_a.repeat_pulse, if_a.held};
    endfunction

    function automatic logic [W-1:0] got_b();
        return {if_b.press_pulse, if_b.release_pulse, if_b.short_click,
                if_b.long_pulse, if_b.repeat_pulse, if_b.held};
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cycle(input string tag, input bit v);
        logic [W-1:0] ea, eb;
        if_a.pb_de = v;
        if_b.pb_de = v;
        exp_q_a.push_back(model_step(0, v));
        exp_q_b.push_back(model_step(1, v));
        @(posedge clk_100);
        #1;
        if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 6'd1, 6'd0);
        end else begin
            ea = exp_q_a.pop_front();
            eb = exp_q_b.pop_front();
            check_eq({tag, "_rep3"}, got_a(), ea);
            check_eq({tag, "_rep1"}, got_b(), eb);
        end
    endtask

    task automatic hold(input string tag, input int hi, input int lo);
        for (int i = 0; i < hi; i++) drive_cycle(tag, 1'b1);
        for (int i = 0; i < lo; i++) drive_cycle(tag, 1'b0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            held_m[d] = 0;
            len_m[d]  = 0;
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        if_a.pb_de = 1'b0;
        if_b.pb_de = 1'b0;
        model_reset();
        #2;
        check_eq("reset_out_a", got_a(), '0);
        check_eq("reset_out_b", got_b(), '0);
        check_eq("reset_state_a", W'(state_a), W'(ST_IDLE));
        @(posedge clk_100);
        #3;
        rst = 1'b0;

        hold("idle", 0, 2);
        hold("short", 3, 2);
        hold("long", 12, 2);
        hold("race", 4, 2);
        drive_cycle("glitch", 1'b1);
        drive_cycle("glitch", 1'b0);
        drive_cycle("glitch", 1'b1);
        drive_cycle("glitch", 1'b0);
        drive_cycle("glitch", 1'b0);
        hold("rep1_hold8", 8, 2);

        for (int k = 0; k < 20; k++)
            hold("random", $urandom_range(1, 14), $urandom_range(1, 3));

        // Asynchronous reset while both decoders are in the long-hold state.
        hold("pre_rst", 8, 0);
        check_eq("in_long_a", W'(state_a), W'(ST_LONG));
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_a", got_a(), '0);
        check_eq("async_rst_b", got_b(), '0);
        check_eq("async_rst_state", W'(state_a), W'(ST_IDLE));
        @(posedge clk_100);
        #1;
        check_eq("rst_hold_a", got_a(), '0);
        check_eq("rst_hold_b", got_b(), '0);
        rst = 1'b0;
        model_reset();
        hold("post_rst", 3, 2);

        if (exp_q_a.size() != 0 || exp_q_b.size() != 0)
            check_eq("queue_drained", W'(exp_q_a.size() + exp_q_b.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
